countdown_timer_bcd: RTL

Parametrised countdown timer for game rounds and serve clocks. Holds a DIGITS-wide BCD count and decrements it once every TICK_DIV clock cycles while running. Supports load, start/resume, pause, an expiry flag and pulse, and per-digit active-low 7-segment outputs. Sits between the game-state controller, which issues commands, and the HEX display pins.

---
 rtl/countdown_timer_bcd.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/countdown_timer_bcd.sv
// BCD countdown timer with prescaled decrement, pause/resume, expiry flag and 7-segment decode.
// Optional macro COUNTDOWN_AUTO_RELOAD_EN: on reaching zero, restart from the last loaded value.
module countdown_timer_bcd #(
   parameter int                  DIGITS    = 2,
   parameter int                  TICK_DIV  = 50000000,
   parameter logic [4*DIGITS-1:0] START_BCD = 8'h60
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  start,
   input  logic                  pause,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [7*DIGITS-1:0]   seg_out,
   output logic                  running,
   output logic                  expired,
   output logic                  tick,
   output logic                  expire_pulse
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   localparam bit AUTO_RELOAD = 1'b1;
`else
   localparam bit AUTO_RELOAD = 1'b0;
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED, ST_EXPIRED} state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         presc_q, presc_d;
   logic [4*DIGITS-1:0]   bcd_q, bcd_d;
   logic [4*DIGITS-1:0]   reload_q, reload_d;
   logic                  tick_q, tick_d;
   logic                  exp_pulse_q, exp_pulse_d;
   logic                  running_q, running_d;
   logic                  expired_q, expired_d;

   logic [4*DIGITS-1:0]   load_clamped;
   logic [4*DIGITS-1:0]   bcd_dec;
   logic [DIGITS-1:0]     borrow;
   logic                  is_zero;
   logic                  dec_zero;

   assign borrow[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         logic [3:0] ld_digit;
         logic [3:0] cur_digit;
         logic [6:0] seg;

         assign ld_digit  = load_val[4*gi +: 4];
         assign cur_digit = bcd_q[4*gi +: 4];
         assign load_clamped[4*gi +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;

         // Ripple borrow: a zero digit wraps to 9 and passes the borrow upward.
         assign bcd_dec[4*gi +: 4] = !borrow[gi]         ? cur_digit :
                                     (cur_digit == 4'd0) ? 4'd9      : cur_digit - 4'd1;
         if (gi < DIGITS - 1) begin : g_borrow
            assign borrow[gi+1] = borrow[gi] & (cur_digit == 4'd0);
         end

         always_comb begin
            seg = 7'b1111111;
            case (cur_digit)
               4'd0:    seg = 7'b1000000;
               4'd1:    seg = 7'b1111001;
               4'd2:    seg = 7'b0100100;
               4'd3:    seg = 7'b0110000;
               4'd4:    seg = 7'b0011001;
               4'd5:    seg = 7'b0010010;
               4'd6:    seg = 7'b0000010;
               4'd7:    seg = 7'b1111000;
               4'd8:    seg = 7'b0000000;
               4'd9:    seg = 7'b0010000;
               default: seg = 7'b1111111;
            endcase
         end
         assign seg_out[7*gi +: 7] = seg;
      end
   endgenerate

   assign is_zero  = (bcd_q == '0);
   assign dec_zero = (bcd_dec == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         presc_q     <= '0;
         bcd_q       <= START_BCD;
         reload_q    <= START_BCD;
         tick_q      <= 1'b0;
         exp_pulse_q <= 1'b0;
         running_q   <= 1'b0;
         expired_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         bcd_q       <= bcd_d;
         reload_q    <= reload_d;
         tick_q      <= tick_d;
         exp_pulse_q <= exp_pulse_d;
         running_q   <= running_d;
         expired_q   <= expired_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      bcd_d       = bcd_q;
      reload_d    = reload_q;
      tick_d      = 1'b0;
      exp_pulse_d = 1'b0;
      if (load) begin
         bcd_d    = load_clamped;
         reload_d = load_clamped;
         presc_d  = '0;
         state_d  = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_PAUSED: begin
               // Prescaler is left untouched so a resume finishes the interrupted period.
               if (start && !is_zero) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (pause) begin
                  state_d = ST_PAUSED;
               end else if (presc_q == PRESC_MAX) begin
                  presc_d = '0;
                  tick_d  = 1'b1;
                  if (AUTO_RELOAD && is_zero) begin
                     bcd_d = reload_q;
                  end else begin
                     bcd_d = bcd_dec;
                     if (dec_zero) begin
                        exp_pulse_d = 1'b1;
                        if (!AUTO_RELOAD || reload_q == '0) state_d = ST_EXPIRED;
                     end
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            ST_EXPIRED: presc_d = '0;
            default:    state_d = ST_IDLE;
         endcase
      end
      running_d = (state_d == ST_RUN);
      expired_d = (state_d == ST_EXPIRED);
   end

   assign bcd_out      = bcd_q;
   assign running      = running_q;
   assign expired      = expired_q;
   assign tick         = tick_q;
   assign expire_pulse = exp_pulse_q;

endmodule
